// File: rtl/multi_door_alarm_ctrl_if.sv
// Signal bundle between the door/ignition front end, the alarm controller and its
// siren, status LED and timer display consumers.
interface multi_door_alarm_ctrl_if #(
  parameter int N_DOORS = 2,
  parameter int TW      = 4
);
  logic               tick_1hz;
  logic               ignition;
  logic               reprogram;
  logic [N_DOORS-1:0] doors;
  logic [TW-1:0]      t_arm_delay;
  logic [TW-1:0]      t_drv_delay;
  logic [TW-1:0]      t_pass_delay;
  logic [TW-1:0]      t_alarm_on;
  logic [2:0]         state;
  logic               siren_en;
  logic               armed;
  logic [1:0]         interval_sel;
  logic [TW-1:0]      count;
  logic [N_DOORS-1:0] trip_door;

  modport master (
    output tick_1hz, ignition, reprogram, doors,
    output t_arm_delay, t_drv_delay, t_pass_delay, t_alarm_on,
    input  state, siren_en, armed, interval_sel, count, trip_door
  );

  modport slave (
    input  tick_1hz, ignition, reprogram, doors,
    input  t_arm_delay, t_drv_delay, t_pass_delay, t_alarm_on,
    output state, siren_en, armed, interval_sel, count, trip_door
  );
endinterface

// File: rtl/multi_door_alarm_ctrl.sv
// N-door anti-theft alarm controller: door edge detection, 1 Hz countdown, entry delay,
// re-triggering siren and a staged ignition/driver-door disarm -> re-arm sequence.
module multi_door_alarm_ctrl #(
  parameter int N_DOORS = 2,
  parameter int TW      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  multi_door_alarm_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    ARMED     = 3'd0,
    TRIGGERED = 3'd1,
    SOUNDING  = 3'd2,
    DIS_IGN   = 3'd3,
    DIS_WAIT  = 3'd4,
    DIS_COUNT = 3'd5
  } state_t;

  localparam logic [1:0] SEL_ARM  = 2'd0;
  localparam logic [1:0] SEL_DRV  = 2'd1;
  localparam logic [1:0] SEL_PASS = 2'd2;
  localparam logic [1:0] SEL_ON   = 2'd3;

  state_t             state_q, state_nxt;
  logic [TW-1:0]      count_q, count_nxt;
  logic [1:0]         sel_q, sel_nxt;
  logic [N_DOORS-1:0] trip_q, trip_nxt;
  logic [N_DOORS-1:0] doors_q;
  logic [N_DOORS-1:0] rise;
  logic               drv_fall;
  logic               siren_q, armed_q;
  logic               counting, expired, any_open;

  // Saturating one-second decrement: the countdown never wraps below zero.
  function automatic logic [TW-1:0] tick_down(input logic [TW-1:0] c, input logic tick);
    return (tick && (c != '0)) ? c - TW'(1) : c;
  endfunction

  assign rise     = bus.doors & ~doors_q;
  assign drv_fall = ~bus.doors[0] & doors_q[0];
  assign any_open = |bus.doors;
  assign counting = (state_q == TRIGGERED) || (state_q == SOUNDING) || (state_q == DIS_COUNT);
  assign expired  = counting && (count_q == '0);

  // Next-state and datapath decode; a load always overrides the tick of the same cycle.
  always_comb begin
    state_nxt = state_q;
    count_nxt = tick_down(count_q, bus.tick_1hz);
    sel_nxt   = sel_q;
    trip_nxt  = trip_q;
    if (bus.reprogram) begin
      state_nxt = ARMED;
      count_nxt = '0;
      sel_nxt   = SEL_DRV;
      trip_nxt  = '0;
    end else if (bus.ignition) begin
      state_nxt = DIS_IGN;
      count_nxt = '0;
      sel_nxt   = SEL_ARM;
      trip_nxt  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (|rise) begin
            state_nxt = TRIGGERED;
            trip_nxt  = rise;
            if (rise[0]) begin
              count_nxt = bus.t_drv_delay;
              sel_nxt   = SEL_DRV;
            end else begin
              count_nxt = bus.t_pass_delay;
              sel_nxt   = SEL_PASS;
            end
          end
        end
        TRIGGERED: begin
          trip_nxt = trip_q | rise;
          if (expired) begin
            state_nxt = SOUNDING;
            count_nxt = bus.t_alarm_on;
            sel_nxt   = SEL_ON;
          end
        end
        SOUNDING: begin
          if (expired) begin
            if (any_open) begin
              count_nxt = bus.t_alarm_on;
            end else begin
              state_nxt = ARMED;
              count_nxt = '0;
              sel_nxt   = SEL_DRV;
              trip_nxt  = '0;
            end
          end
        end
        DIS_IGN: begin
          state_nxt = DIS_WAIT;
          count_nxt = '0;
          sel_nxt   = SEL_ARM;
        end
        DIS_WAIT: begin
          if (drv_fall && !any_open) begin
            state_nxt = DIS_COUNT;
            count_nxt = bus.t_arm_delay;
            sel_nxt   = SEL_ARM;
          end
        end
        DIS_COUNT: begin
          // Any open door restarts the wait for a fresh driver-door close.
          if (any_open) begin
            state_nxt = DIS_WAIT;
            count_nxt = '0;
          end else if (expired) begin
            state_nxt = ARMED;
            count_nxt = '0;
            sel_nxt   = SEL_DRV;
            trip_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ARMED;
          count_nxt = '0;
          sel_nxt   = SEL_DRV;
          trip_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARMED;
      count_q <= '0;
      sel_q   <= SEL_DRV;
      trip_q  <= '0;
      doors_q <= '0;
      siren_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      sel_q   <= sel_nxt;
      trip_q  <= trip_nxt;
      doors_q <= bus.doors;
      siren_q <= (state_nxt == SOUNDING);
      armed_q <= (state_nxt == ARMED);
    end
  end

  assign bus.state        = state_q;
  assign bus.siren_en     = siren_q;
  assign bus.armed        = armed_q;
  assign bus.interval_sel = sel_q;
  assign bus.count        = count_q;
  assign bus.trip_door    = trip_q;

  a_siren_decode: assert property (@(posedge clock) disable iff (reset)
    siren_q == (state_q == SOUNDING));
  a_armed_decode: assert property (@(posedge clock) disable iff (reset)
    armed_q == (state_q == ARMED));
  a_idle_count_zero: assert property (@(posedge clock) disable iff (reset)
    counting || (count_q == '0));
endmodule

// File: tb/tb_multi_door_alarm_ctrl.sv
// Bench for multi_door_alarm_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_multi_door_alarm_ctrl;
  localparam int N  = 2;
  localparam int TW = 4;
  localparam int OW = 3 + 1 + 1 + 2 + TW + N;
  localparam int S_ARMED = 0, S_TRIG = 1, S_SOUND = 2, S_DIGN = 3, S_DWAIT = 4, S_DCNT = 5;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multi_door_alarm_ctrl_if #(.N_DOORS(N), .TW(TW)) bus();
  multi_door_alarm_ctrl #(.N_DOORS(N), .TW(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int            m_st;
  logic [TW-1:0] m_cnt;
  logic [1:0]    m_sel;
  logic [N-1:0]  m_trip;
  logic [N-1:0]  m_prev;

  task automatic go(input int st, input logic [TW-1:0] c, input logic [1:0] sel);
    m_st  = st;
    m_cnt = c;
    m_sel = sel;
  endtask

  // Applies the controller rules once per clock edge, in priority order.
  task automatic model_edge();
    logic [N-1:0]  d, rise, fall;
    logic          timed, expired;
    d       = bus.doors;
    rise    = d & ~m_prev;
    fall    = ~d & m_prev;
    timed   = (m_st == S_TRIG) || (m_st == S_SOUND) || (m_st == S_DCNT);
    expired = timed && (m_cnt == 0);
    m_prev  = d;
    if (reset) begin
      m_prev = '0; m_trip = '0; go(S_ARMED, '0, 2'd1);
      return;
    end
    if (bus.reprogram) begin
      m_trip = '0; go(S_ARMED, '0, 2'd1);
      return;
    end
    if (bus.ignition) begin
      m_trip = '0; go(S_DIGN, '0, 2'd0);
      return;
    end
    if (bus.tick_1hz && m_cnt > 0) m_cnt = m_cnt - TW'(1);
    case (m_st)
      S_ARMED:
        if (rise != 0) begin
          m_trip = rise;
          if (rise[0]) go(S_TRIG, bus.t_drv_delay, 2'd1);
          else go(S_TRIG, bus.t_pass_delay, 2'd2);
        end
      S_TRIG: begin
        m_trip = m_trip | rise;
        if (expired) go(S_SOUND, bus.t_alarm_on, 2'd3);
      end
      S_SOUND:
        if (expired) begin
          if (d != 0) go(S_SOUND, bus.t_alarm_on, 2'd3);
          else begin m_trip = '0; go(S_ARMED, '0, 2'd1); end
        end
      S_DIGN: go(S_DWAIT, '0, 2'd0);
      S_DWAIT: if (fall[0] && d == 0) go(S_DCNT, bus.t_arm_delay, 2'd0);
      S_DCNT:
        if (d != 0) go(S_DWAIT, '0, 2'd0);
        else if (expired) begin m_trip = '0; go(S_ARMED, '0, 2'd1); end
      default: go(S_ARMED, '0, 2'd1);
    endcase
  endtask

  function automatic logic [OW-1:0] observed();
    return {bus.state, bus.siren_en, bus.armed, bus.interval_sel, bus.count, bus.trip_door};
  endfunction

  function automatic logic [OW-1:0] predicted();
    return {3'(m_st), (m_st == S_SOUND), (m_st == S_ARMED), m_sel, m_cnt, m_trip};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic idle();
    bus.tick_1hz = 1'b0; bus.ignition = 1'b0; bus.reprogram = 1'b0; bus.doors = '0;
    bus.t_arm_delay = '0; bus.t_drv_delay = '0; bus.t_pass_delay = '0; bus.t_alarm_on = '0;
  endtask

  task automatic clear_to_armed();
    bus.reprogram = 1'b1; bus.ignition = 1'b0; bus.doors = '0;
    step();
    bus.reprogram = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    checks++;
    if (observed() !== {3'd0, 1'b0, 1'b1, 2'd1, 4'd0, 2'b00}) begin
      failures++; $display("FAIL reset_values got=%h want=%h", observed(), {3'd0, 1'b0, 1'b1, 2'd1, 4'd0, 2'b00});
    end
    reset = 1'b0;
    step();
    checks++;
    if (observed() !== predicted()) begin
      failures++; $display("FAIL reset_release got=%h want=%h", observed(), predicted());
    end
  endtask

  task automatic test_driver_trip();
    clear_to_armed();
    bus.t_drv_delay = 4'd3; bus.t_alarm_on = 4'd6; bus.doors = 2'b01;
    step();
    checks++;
    if (bus.state !== 3'd1 || bus.count !== 4'd3 || bus.interval_sel !== 2'd1 || bus.trip_door !== 2'b01) begin
      failures++; $display("FAIL drv_trip_load state=%0d count=%0d sel=%0d trip=%b want 1/3/1/01",
        bus.state, bus.count, bus.interval_sel, bus.trip_door);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++;
      if (observed() !== predicted()) begin
        failures++; $display("FAIL drv_trip_tick%0d got=%h want=%h", i, observed(), predicted());
      end
    end
    checks++;
    if (bus.state !== 3'd1 || bus.count !== 4'd0 || bus.siren_en !== 1'b0) begin
      failures++; $display("FAIL drv_trip_zero state=%0d count=%0d siren=%b want 1/0/0", bus.state, bus.count, bus.siren_en);
    end
    step();
    checks++;
    if (bus.state !== 3'd2 || bus.siren_en !== 1'b1 || bus.count !== 4'd6 || bus.interval_sel !== 2'd3) begin
      failures++; $display("FAIL drv_trip_sound state=%0d siren=%b count=%0d sel=%0d want 2/1/6/3",
        bus.state, bus.siren_en, bus.count, bus.interval_sel);
    end
  endtask

  task automatic test_pass_trip();
    clear_to_armed();
    bus.t_pass_delay = 4'd5; bus.t_drv_delay = 4'd3; bus.doors = 2'b10;
    step();
    checks++;
    if (bus.state !== 3'd1 || bus.interval_sel !== 2'd2 || bus.count !== 4'd5 || bus.trip_door !== 2'b10) begin
      failures++; $display("FAIL pass_trip state=%0d sel=%0d count=%0d trip=%b want 1/2/5/10",
        bus.state, bus.interval_sel, bus.count, bus.trip_door);
    end
    bus.doors = 2'b11;
    step();
    checks++;
    if (bus.trip_door !== 2'b11 || bus.count !== 4'd5 || bus.interval_sel !== 2'd2) begin
      failures++; $display("FAIL pass_trip_or trip=%b count=%0d sel=%0d want 11/5/2", bus.trip_door, bus.count, bus.interval_sel);
    end
    clear_to_armed();
    bus.doors = 2'b11;
    step();
    checks++;
    if (bus.interval_sel !== 2'd1 || bus.count !== 4'd3 || bus.trip_door !== 2'b11) begin
      failures++; $display("FAIL both_trip sel=%0d count=%0d trip=%b want 1/3/11", bus.interval_sel, bus.count, bus.trip_door);
    end
    checks++;
    if (observed() !== predicted()) begin
      failures++; $display("FAIL both_trip_model got=%h want=%h", observed(), predicted());
    end
  endtask

  task automatic test_sounding_reload();
    clear_to_armed();
    bus.t_drv_delay = 4'd0; bus.t_alarm_on = 4'd2; bus.doors = 2'b01;
    step(); step();
    checks++;
    if (bus.state !== 3'd2 || bus.count !== 4'd2 || bus.siren_en !== 1'b1) begin
      failures++; $display("FAIL sound_enter state=%0d count=%0d siren=%b want 2/2/1", bus.state, bus.count, bus.siren_en);
    end
    pulse_tick(); pulse_tick(); step();
    checks++;
    if (bus.state !== 3'd2 || bus.count !== 4'd2) begin
      failures++; $display("FAIL sound_reload state=%0d count=%0d want 2/2", bus.state, bus.count);
    end
    bus.doors = 2'b00;
    pulse_tick(); pulse_tick(); step();
    checks++;
    if (bus.state !== 3'd0 || bus.trip_door !== 2'b00 || bus.siren_en !== 1'b0 || bus.armed !== 1'b1) begin
      failures++; $display("FAIL sound_end state=%0d trip=%b siren=%b armed=%b want 0/00/0/1",
        bus.state, bus.trip_door, bus.siren_en, bus.armed);
    end
  endtask

  task automatic test_disarm_sequence();
    clear_to_armed();
    bus.t_arm_delay = 4'd4; bus.ignition = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'd3 || bus.interval_sel !== 2'd0 || bus.count !== 4'd0) begin
      failures++; $display("FAIL dis_ign state=%0d sel=%0d count=%0d want 3/0/0", bus.state, bus.interval_sel, bus.count);
    end
    bus.ignition = 1'b0;
    step();
    bus.doors = 2'b01; step();
    bus.doors = 2'b00; step();
    checks++;
    if (bus.state !== 3'd5 || bus.count !== 4'd4) begin
      failures++; $display("FAIL dis_count state=%0d count=%0d want 5/4", bus.state, bus.count);
    end
    pulse_tick(); pulse_tick();
    bus.doors = 2'b10; step();
    checks++;
    if (bus.state !== 3'd4) begin
      failures++; $display("FAIL dis_reopen state=%0d want 4", bus.state);
    end
    bus.doors = 2'b00; step();
    checks++;
    if (bus.state !== 3'd4) begin
      failures++; $display("FAIL dis_pass_close state=%0d want 4", bus.state);
    end
    bus.doors = 2'b01; step();
    bus.doors = 2'b00; step();
    checks++;
    if (bus.state !== 3'd5 || bus.count !== 4'd4) begin
      failures++; $display("FAIL dis_recount state=%0d count=%0d want 5/4", bus.state, bus.count);
    end
    for (int i = 0; i < 4; i++) pulse_tick();
    step();
    checks++;
    if (bus.state !== 3'd0 || bus.armed !== 1'b1 || observed() !== predicted()) begin
      failures++; $display("FAIL dis_rearm got=%h want=%h", observed(), predicted());
    end
  endtask

  task automatic test_reprogram();
    clear_to_armed();
    bus.t_drv_delay = 4'd5; bus.doors = 2'b01;
    step();
    pulse_tick(); pulse_tick(); pulse_tick();
    checks++;
    if (bus.state !== 3'd1 || bus.count !== 4'd2) begin
      failures++; $display("FAIL reprog_setup state=%0d count=%0d want 1/2", bus.state, bus.count);
    end
    bus.reprogram = 1'b1; step();
    checks++;
    if (bus.state !== 3'd0 || bus.count !== 4'd0 || bus.trip_door !== 2'b00) begin
      failures++; $display("FAIL reprog_force state=%0d count=%0d trip=%b want 0/0/00", bus.state, bus.count, bus.trip_door);
    end
    bus.doors = 2'b00; step();
    bus.doors = 2'b01; step();
    bus.reprogram = 1'b0; step();
    checks++;
    if (bus.state !== 3'd0) begin
      failures++; $display("FAIL reprog_hold state=%0d want 0", bus.state);
    end
    bus.ignition = 1'b1; bus.reprogram = 1'b1; step();
    checks++;
    if (bus.state !== 3'd0 || bus.armed !== 1'b1) begin
      failures++; $display("FAIL reprog_over_ign state=%0d armed=%b want 0/1", bus.state, bus.armed);
    end
    bus.ignition = 1'b0; bus.reprogram = 1'b0; bus.doors = 2'b00; step();
  endtask

  task automatic test_reset_mid_sounding();
    clear_to_armed();
    bus.t_drv_delay = 4'd0; bus.t_alarm_on = 4'd9; bus.doors = 2'b01;
    step(); step();
    checks++;
    if (bus.state !== 3'd2 || bus.siren_en !== 1'b1) begin
      failures++; $display("FAIL rst_setup state=%0d siren=%b want 2/1", bus.state, bus.siren_en);
    end
    reset = 1'b1; step();
    checks++;
    if (observed() !== {3'd0, 1'b0, 1'b1, 2'd1, 4'd0, 2'b00}) begin
      failures++; $display("FAIL rst_mid got=%h want=%h", observed(), {3'd0, 1'b0, 1'b1, 2'd1, 4'd0, 2'b00});
    end
    bus.t_drv_delay = 4'd7; step();
    reset = 1'b0; step();
    checks++;
    if (bus.state !== 3'd1 || bus.trip_door !== 2'b01 || bus.count !== 4'd7 || bus.interval_sel !== 2'd1) begin
      failures++; $display("FAIL rst_open_door state=%0d trip=%b count=%0d sel=%0d want 1/01/7/1",
        bus.state, bus.trip_door, bus.count, bus.interval_sel);
    end
  endtask

  task automatic test_random();
    clear_to_armed();
    for (int i = 0; i < 3000; i++) begin
      bus.tick_1hz  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) bus.doors = N'($urandom_range(0, (1 << N) - 1));
      if (bus.ignition) bus.ignition = ($urandom_range(0, 7) != 0);
      else bus.ignition = ($urandom_range(0, 80) == 0);
      bus.reprogram = ($urandom_range(0, 90) == 0);
      reset = ($urandom_range(0, 500) == 0);
      bus.t_arm_delay  = TW'($urandom_range(0, 3));
      bus.t_drv_delay  = TW'($urandom_range(0, 3));
      bus.t_pass_delay = TW'($urandom_range(0, 3));
      bus.t_alarm_on   = TW'($urandom_range(0, 3));
      step();
      checks++;
      if (observed() !== predicted()) begin
        failures++; $display("FAIL random_cycle%0d got=%h want=%h", i, observed(), predicted());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_driver_trip();
    test_pass_trip();
    test_sounding_reload();
    test_disarm_sequence();
    test_reprogram();
    test_reset_mid_sounding();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
